// File: rtl/multicycle_alu.sv
// Registered multi-cycle ALU: single-cycle logic/arith/shift/compare ops plus
// iterative shift-add unsigned multiply and restoring unsigned divide, with a
// start/busy/done handshake towards the multi-cycle controller.
module multicycle_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic             ALUSrcB,
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [WIDTH-1:0] extended_immediate,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero
);

  localparam int unsigned S   = $clog2(WIDTH);
  localparam int unsigned Msb = WIDTH - 1;
  localparam logic [S-1:0] LastCnt = S'(WIDTH - 1);

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpRsub = 4'h2;
  localparam logic [3:0] OpOr   = 4'h3;
  localparam logic [3:0] OpAnd  = 4'h4;
  localparam logic [3:0] OpAndn = 4'h5;
  localparam logic [3:0] OpXor  = 4'h6;
  localparam logic [3:0] OpXnor = 4'h7;
  localparam logic [3:0] OpSll  = 4'h8;
  localparam logic [3:0] OpSrl  = 4'h9;
  localparam logic [3:0] OpSra  = 4'hA;
  localparam logic [3:0] OpSlt  = 4'hB;
  localparam logic [3:0] OpSltu = 4'hC;
  localparam logic [3:0] OpMulu = 4'hD;
  localparam logic [3:0] OpDivu = 4'hE;

  typedef enum logic [1:0] {StIdle, StExec, StFinish} state_e;

  state_e           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_zero;
  logic             r_overflow;
  logic             r_div_zero;

  // Iterative datapath: r_hi/r_lo hold product-high/multiplier for MULU and
  // remainder/dividend-quotient for DIVU; r_opnd is multiplicand or divisor.
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic             r_is_div;
  logic [S-1:0]     r_cnt;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [S-1:0]     w_shamt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff_ab;
  logic [WIDTH-1:0] w_diff_ba;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;
  logic             w_is_multi;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH-1:0] w_div_diff;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;

  assign w_a        = read_data1;
  assign w_b        = ALUSrcB ? extended_immediate : read_data2;
  assign w_shamt    = read_data1[S-1:0];
  assign w_sum      = w_a + w_b;
  assign w_diff_ab  = w_a - w_b;
  assign w_diff_ba  = w_b - w_a;
  assign w_is_multi = (ALUOp == OpMulu) || (ALUOp == OpDivu);

  // Single-cycle result and signed-overflow flag from the live operands.
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (ALUOp)
      OpAdd: begin
        w_alu_res = w_sum;
        w_alu_ovf = (w_a[Msb] == w_b[Msb]) && (w_sum[Msb] != w_a[Msb]);
      end
      OpSub: begin
        w_alu_res = w_diff_ab;
        w_alu_ovf = (w_a[Msb] != w_b[Msb]) && (w_diff_ab[Msb] != w_a[Msb]);
      end
      OpRsub: begin
        w_alu_res = w_diff_ba;
        w_alu_ovf = (w_b[Msb] != w_a[Msb]) && (w_diff_ba[Msb] != w_b[Msb]);
      end
      OpOr:   w_alu_res = w_a | w_b;
      OpAnd:  w_alu_res = w_a & w_b;
      OpAndn: w_alu_res = ~w_a & w_b;
      OpXor:  w_alu_res = w_a ^ w_b;
      OpXnor: w_alu_res = ~(w_a ^ w_b);
      OpSll:  w_alu_res = w_b << w_shamt;
      OpSrl:  w_alu_res = w_b >> w_shamt;
      OpSra:  w_alu_res = $signed(w_b) >>> w_shamt;
      OpSlt:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      OpSltu: w_alu_res = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
      default: begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
      end
    endcase
  end

  // One iteration of shift-add multiply / restoring divide.
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    w_mul_hi    = w_mul_sum[WIDTH:1];
    w_mul_lo    = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_ge    = w_div_shift >= {1'b0, r_opnd};
    // Partial remainder stays below the divisor, so the difference fits WIDTH bits.
    w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
    w_div_hi    = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
    w_div_lo    = {r_lo[WIDTH-2:0], w_div_ge};
    w_step_hi   = r_is_div ? w_div_hi : w_mul_hi;
    w_step_lo   = r_is_div ? w_div_lo : w_mul_lo;
  end

  // Control FSM with registered handshake and result outputs.
  // A zero divisor needs no special case: every trial subtraction succeeds,
  // giving an all-ones quotient and the dividend as remainder.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state     <= StIdle;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b1;
      r_overflow  <= 1'b0;
      r_div_zero  <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opnd      <= '0;
      r_is_div    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_busy <= 1'b1;
            if (w_is_multi) begin
              r_is_div <= (ALUOp == OpDivu);
              r_cnt    <= '0;
              r_hi     <= '0;
              if (ALUOp == OpDivu) begin
                r_opnd <= w_b;
                r_lo   <= w_a;
              end else begin
                r_opnd <= w_a;
                r_lo   <= w_b;
              end
              r_state <= StExec;
            end else begin
              r_result    <= w_alu_res;
              r_result_hi <= '0;
              r_zero      <= (w_alu_res == '0);
              r_overflow  <= w_alu_ovf;
              r_div_zero  <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= StFinish;
            end
          end
        end
        StExec: begin
          r_hi  <= w_step_hi;
          r_lo  <= w_step_lo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LastCnt) begin
            r_result    <= w_step_lo;
            r_result_hi <= w_step_hi;
            r_zero      <= (w_step_lo == '0);
            r_overflow  <= 1'b0;
            r_div_zero  <= r_is_div && (r_opnd == '0);
            r_done      <= 1'b1;
            r_state     <= StFinish;
          end
        end
        StFinish: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: table of directed vectors plus
// hand-written sequences for busy/start-ignore and reset during a divide.
module tb_multicycle_alu;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        start;
  logic [3:0]  ALUOp;
  logic        ALUSrcB;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] extended_immediate;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        zero;
  logic        overflow;
  logic        div_zero;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  op;
    logic        srcb;
    logic [31:0] a;
    logic [31:0] b2;
    logic [31:0] imm;
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        ov;
    logic        dz;
    int          lat;
  } vec_t;

  localparam int NVec = 21;
  vec_t vecs[NVec];

  multicycle_alu #(.WIDTH(32)) dut (
    .CLK                (CLK),
    .Reset              (Reset),
    .start              (start),
    .ALUOp              (ALUOp),
    .ALUSrcB            (ALUSrcB),
    .read_data1         (read_data1),
    .read_data2         (read_data2),
    .extended_immediate (extended_immediate),
    .busy               (busy),
    .done               (done),
    .result             (result),
    .result_hi          (result_hi),
    .zero               (zero),
    .overflow           (overflow),
    .div_zero           (div_zero)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " busy"}, 64'(busy), 64'd0);
    chk({nm, " done"}, 64'(done), 64'd0);
    chk({nm, " result"}, 64'(result), 64'd0);
    chk({nm, " result_hi"}, 64'(result_hi), 64'd0);
    chk({nm, " zero"}, 64'(zero), 64'd1);
    chk({nm, " overflow"}, 64'(overflow), 64'd0);
    chk({nm, " div_zero"}, 64'(div_zero), 64'd0);
  endtask

  // Apply one operation, scramble inputs after the start cycle, wait for done.
  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    @(negedge CLK);
    ALUOp = v.op; ALUSrcB = v.srcb;
    read_data1 = v.a; read_data2 = v.b2; extended_immediate = v.imm;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    ALUOp = 4'($urandom); ALUSrcB = 1'($urandom);
    read_data1 = $urandom; read_data2 = $urandom; extended_immediate = $urandom;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge CLK);
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(v.lat));
    chk({nm, " result"}, 64'(result), 64'(v.res));
    chk({nm, " result_hi"}, 64'(result_hi), 64'(v.hi));
    chk({nm, " zero"}, 64'(zero), 64'(v.z));
    chk({nm, " overflow"}, 64'(overflow), 64'(v.ov));
    chk({nm, " div_zero"}, 64'(div_zero), 64'(v.dz));
    chk({nm, " busy@done"}, 64'(busy), 64'd1);
    @(negedge CLK);
    chk({nm, " done pulse"}, 64'(done), 64'd0);
    chk({nm, " busy after"}, 64'(busy), 64'd0);
    chk({nm, " hold"}, 64'(result), 64'(v.res));
  endtask

  initial begin
    int lat;
    int bad;
    vec_t v;

    vecs[0]  = '{4'h0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{4'h1, 1'b1, 32'h0000_0005, 32'h0000_0123, 32'h5, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{4'h2, 1'b0, 32'h0000_0003, 32'h0000_0001, 32'h0, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'h1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h0, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1};
    vecs[4]  = '{4'h3, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0, 32'hF0F0_0F0F, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'h4, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0, 32'h0F00_0F00, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'h5, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0, 32'h000F_000F, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{4'h6, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 32'hEDCB_A987, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{4'h7, 1'b0, 32'h55AA_55AA, 32'h55AA_55AA, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'h8, 1'b0, 32'h0000_0023, 32'h0000_0001, 32'h0, 32'h0000_0008, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{4'h9, 1'b0, 32'h0000_0004, 32'h8000_0000, 32'h0, 32'h0800_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{4'hA, 1'b0, 32'h0000_0004, 32'h8000_0000, 32'h0, 32'hF800_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{4'hB, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[13] = '{4'hC, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
    vecs[14] = '{4'hF, 1'b0, 32'h0000_0005, 32'h0000_0006, 32'h0, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
    vecs[15] = '{4'hD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 33};
    vecs[16] = '{4'hD, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 33};
    vecs[17] = '{4'hE, 1'b0, 32'd100, 32'd7, 32'h0, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 33};
    vecs[18] = '{4'hE, 1'b0, 32'd9, 32'd0, 32'h0, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b0, 1'b1, 33};
    vecs[19] = '{4'hE, 1'b1, 32'hFFFF_FFFF, 32'd3, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0, 1'b0, 33};
    vecs[20] = '{4'h0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0000_0000, 32'h0, 1'b1, 1'b1, 1'b0, 1};

    Reset = 1'b1; start = 1'b0; ALUOp = 4'h0; ALUSrcB = 1'b0;
    read_data1 = '0; read_data2 = '0; extended_immediate = '0;
    repeat (2) @(negedge CLK);
    chk_reset_vals("reset");
    Reset = 1'b0;

    for (int i = 0; i < NVec; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // MULU with start pulses hammered throughout, including the done cycle.
    run_vec(vecs[4], "pre-mul");
    @(negedge CLK);
    ALUOp = 4'hD; ALUSrcB = 1'b0; read_data1 = 32'h0000_1234; read_data2 = 32'h0000_0010;
    start = 1'b1;
    @(negedge CLK);
    lat = 1;
    bad = 0;
    while (!done && lat < 100) begin
      ALUOp = 4'h0; read_data1 = $urandom; read_data2 = $urandom; start = 1'b1;
      if (!busy || result !== 32'hF0F0_0F0F) bad++;
      @(negedge CLK);
      lat++;
    end
    chk("mul-busy busy/hold during exec", 64'(bad), 64'd0);
    chk("mul-busy latency", 64'(lat), 64'd33);
    chk("mul-busy result", 64'(result), 64'h0001_2340);
    chk("mul-busy result_hi", 64'(result_hi), 64'd0);
    @(negedge CLK);
    start = 1'b0;
    chk("mul-busy start in done cycle ignored", 64'(busy), 64'd0);
    chk("mul-busy done pulse", 64'(done), 64'd0);

    // Reset in the middle of a divide, then a normal divide.
    run_vec(vecs[0], "pre-div");
    @(negedge CLK);
    ALUOp = 4'hE; ALUSrcB = 1'b0; read_data1 = 32'd100; read_data2 = 32'd7; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (9) @(negedge CLK);
    chk("div-rst busy before reset", 64'(busy), 64'd1);
    Reset = 1'b1;
    #1;
    chk_reset_vals("div-rst");
    @(negedge CLK);
    Reset = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge CLK);
      if (busy || done) bad++;
    end
    chk("div-rst stays idle", 64'(bad), 64'd0);
    v = vecs[17];
    run_vec(v, "post-rst div");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
